// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one single-port word memory between
//            instruction fetch (port 0) and load/store (port 1).
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int DEPTH = 10,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          busy,
    output logic          mem_WE,
    output logic [AW-1:0] mem_Addr,
    output logic [DW-1:0] mem_DataIn,
    input  logic [DW-1:0] mem_DataOut
);

    localparam logic [AW-1:0] c_DEPTH = AW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last_grant;
    logic            r_gid;
    logic            r_cmd_we;
    logic [AW-1:0]   r_cmd_addr;
    logic [DW-1:0]   r_cmd_wdata;

    logic            w_winner;
    logic            w_any_req;
    logic            w_in_range;
    logic [DW-1:0]   w_rd_result;

    // Contention goes to the port that was not granted last; last_grant
    // resets to 1 so the first contended grant lands on port 0.
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = req1;
        end
    end

    assign w_in_range  = (r_cmd_addr < c_DEPTH);
    assign w_rd_result = (w_in_range && !r_cmd_we) ? mem_DataOut : '0;

    assign busy       = (r_state != S_IDLE);
    assign mem_Addr   = r_cmd_addr;
    assign mem_DataIn = r_cmd_wdata;
    // Derived from state so an async reset kills the write in the same cycle.
    assign mem_WE     = (r_state == S_ACCESS) && r_cmd_we && w_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_gid        <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cmd_we     <= w_winner ? we1    : we0;
                        r_cmd_addr   <= w_winner ? addr1  : addr0;
                        r_cmd_wdata  <= w_winner ? wdata1 : wdata0;
                        r_gid        <= w_winner;
                        r_last_grant <= w_winner;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_gid) begin
                        ack1   <= 1'b1;
                        err1   <= !w_in_range;
                        rdata1 <= w_rd_result;
                    end else begin
                        ack0   <= 1'b1;
                        err0   <= !w_in_range;
                        rdata0 <= w_rd_result;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    err0    <= 1'b0;
                    err1    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and randomized self-checking bench for mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, busy, mem_WE;
    logic [31:0] rdata0, rdata1, mem_Addr, mem_DataIn, mem_DataOut;

    mem_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .mem_WE(mem_WE), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
        .mem_DataOut(mem_DataOut)
    );

    always #5 clk = ~clk;

    // Attached memory: async read, garbage outside the array so a leaked read shows up.
    logic [31:0] mem [0:15];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        oob_we_seen = 1'b0;
    logic        both_ack_seen = 1'b0;
    int          we_cnt = 0;

    assign mem_DataOut = (mem_Addr < 32'(DEPTH)) ? mem[mem_Addr[3:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_WE) begin
            if (mem_Addr < 32'(DEPTH)) mem[mem_Addr[3:0]] <= mem_DataIn;
            else oob_we_seen <= 1'b1;
        end
        if (mem_WE) we_cnt <= we_cnt + 1;
        if (ack0 && ack1) both_ack_seen <= 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 4'(a); ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int p, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction
    function automatic logic err_of(input int p);
        return (p == 0) ? err0 : err1;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? rdata0 : rdata1;
    endfunction

    // One complete access on an idle arbiter; lat counts edges until ack is visible.
    task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat, output int bz);
        lat = 0; bz = 0;
        set_req(p, 1'b1, w, a, d);
        while (lat < 12) begin
            tick(); lat++;
            if (busy) bz++;
            if (ack_of(p)) break;
        end
        rd = rdata_of(p); er = err_of(p);
        set_req(p, 1'b0, 1'b0, '0, '0);
        tick();
        if (busy) bz++;
    endtask

    // Transaction-level reference state for the randomized phase
    logic [31:0] ref_mem [0:DEPTH-1];
    logic        pend [2];
    logic        fresh [2];
    int          vis [2];
    logic        cwe [2];
    logic [31:0] caddr [2];
    logic [31:0] cwd [2];
    logic [31:0] rexp [2];
    int          last_srv;

    initial begin
        logic [31:0] rd, v;
        logic        er;
        int          lat, bz, w0, e, g, nack;
        int          ack_port [4];
        int          ack_time [4];

        // Reset asserted while a write is in ACCESS
        reset_dut();
        poke(2, 32'h0000_AAAA);
        set_req(0, 1'b1, 1'b1, 32'd2, 32'h0000_5555);
        tick();
        chk("t1_we_in_access", mem_WE, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("t1_we_killed", mem_WE, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_outs", {ack0, ack1, err0, err1, rdata0, rdata1}, '0);
        tick();
        chk("t1_mem_kept", mem[2], 32'h0000_AAAA);
        set_req(0, 1'b0, 1'b0, '0, '0);
        reset_n = 1'b1;
        tick();
        chk("t1_idle_after", {busy, ack0}, 2'b00);

        // Single read
        poke(3, 32'hDEAD_BEEF);
        access(0, 1'b0, 32'd3, '0, rd, er, lat, bz);
        chk("t2_rdata", rd, 32'hDEAD_BEEF);
        chk("t2_err", er, 1'b0);
        chk("t2_latency", lat, 2);
        chk("t2_busy_cycles", bz, 2);

        // Write then read back on port 1
        w0 = we_cnt;
        access(1, 1'b1, 32'd5, 32'h1234_5678, rd, er, lat, bz);
        chk("t3_write_rdata_zero", rd, 32'h0);
        chk("t3_we_one_cycle", we_cnt - w0, 1);
        access(1, 1'b0, 32'd5, '0, rd, er, lat, bz);
        chk("t3_readback", rd, 32'h1234_5678);

        // Range boundary
        w0 = we_cnt;
        poke(9, 32'h0909_0909);
        access(1, 1'b1, 32'd10, 32'hFFFF_FFFF, rd, er, lat, bz);
        chk("t5_oob_err", er, 1'b1);
        chk("t5_oob_rdata", rd, 32'h0);
        chk("t5_oob_no_we", we_cnt - w0, 0);
        access(1, 1'b0, 32'd9, '0, rd, er, lat, bz);
        chk("t5_last_err", er, 1'b0);
        chk("t5_last_rdata", rd, 32'h0909_0909);
        access(0, 1'b0, 32'h0000_0103, '0, rd, er, lat, bz);
        chk("t5_wide_err", er, 1'b1);
        chk("t5_wide_rdata", rd, 32'h0);

        // Withdrawn request is dropped
        set_req(0, 1'b1, 1'b0, 32'd4, '0);
        tick();
        set_req(1, 1'b1, 1'b0, 32'd7, '0);
        tick();
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack1) nack++;
        end
        chk("t6_no_ack1", nack, 0);
        chk("t6_idle", busy, 1'b0);

        // Contention from reset alternates starting with port 0
        reset_dut();
        for (int i = 0; i < 4; i++) begin ack_port[i] = -1; ack_time[i] = -1; end
        set_req(0, 1'b1, 1'b0, 32'd1, '0);
        set_req(1, 1'b1, 1'b0, 32'd2, '0);
        nack = 0;
        for (int t = 1; t <= 30 && nack < 4; t++) begin
            tick();
            if (ack0 || ack1) begin
                ack_port[nack] = ack1 ? 1 : 0;
                ack_time[nack] = t;
                nack++;
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick(); tick();
        chk("t4_first_time", ack_time[0], 2);
        for (int i = 0; i < 4; i++) chk("t4_order", ack_port[i], i % 2);
        for (int i = 1; i < 4; i++) chk("t4_spacing", ack_time[i] - ack_time[i-1], 3);

        // Randomized traffic against the transaction-level model
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            poke(i, v);
        end
        last_srv = 1;
        e = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; fresh[p] = 1'b0; rexp[p] = '0; vis[p] = 0;
            cwe[p] = 1'b0; caddr[p] = '0; cwd[p] = '0;
        end
        for (int t = 0; t < 500; t++) begin
            tick(); e++;
            for (int p = 0; p < 2; p++) begin
                if (ack_of(p)) begin
                    chk("rnd_ack_pending", pend[p], 1'b1);
                    g = e - 1;
                    if (pend[1-p] && vis[1-p] <= g) chk("rnd_rr_winner", p, 1 - last_srv);
                    if (caddr[p] < 32'(DEPTH)) begin
                        if (cwe[p]) begin
                            ref_mem[int'(caddr[p])] = cwd[p];
                            rexp[p] = '0;
                        end else begin
                            rexp[p] = ref_mem[int'(caddr[p])];
                        end
                    end else begin
                        rexp[p] = '0;
                    end
                    chk("rnd_err", err_of(p), caddr[p] >= 32'(DEPTH));
                    last_srv = p;
                    pend[p] = 1'b0;
                    fresh[p] = 1'b1;
                    set_req(p, 1'b0, 1'b0, '0, '0);
                end else begin
                    if (pend[p]) chk("rnd_latency", (e - vis[p]) <= 6, 1'b1);
                    chk("rnd_err_idle", err_of(p), 1'b0);
                end
                chk("rnd_rdata", rdata_of(p), rexp[p]);
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !fresh[p] && ($urandom_range(0, 1) == 1)) begin
                    v = 32'($urandom_range(0, 15));
                    caddr[p] = (v == 32'd15) ? (32'h8000_0000 | 32'($urandom_range(0, 9))) : v;
                    cwe[p]   = 1'($urandom_range(0, 1));
                    cwd[p]   = $urandom;
                    pend[p]  = 1'b1;
                    vis[p]   = e + 1;
                    set_req(p, 1'b1, cwe[p], caddr[p], cwd[p]);
                end
                fresh[p] = 1'b0;
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        tick(); tick(); tick();

        chk("never_both_ack", both_ack_seen, 1'b0);
        chk("never_oob_write", oob_we_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
